// File: rtl/arb_pkg.sv
// Shared types and reset values for the arbiter requester agent.
package arb_pkg;

  localparam int BEAT_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, XFER} req_state_t;

  typedef struct packed {
    logic                   last;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

  localparam req_state_t STATE_RST = IDLE;
  localparam logic       ERR_RST   = 1'b0;

endpackage

// File: rtl/arb_requester_if.sv
// Producer, arbiter and bus signals of one requester slot.
interface arb_requester_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              req;
  logic              gnt;
  logic              release_pulse;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              bus_ready;
  logic              starve;
  logic              err;

  modport master (
    input  in_valid, in_data, in_last, gnt, bus_ready,
    output in_ready, req, release_pulse, bus_valid, bus_data, bus_last, starve, err
  );

  modport slave (
    output in_valid, in_data, in_last, gnt, bus_ready,
    input  in_ready, req, release_pulse, bus_valid, bus_data, bus_last, starve, err
  );
endinterface

// File: rtl/arb_requester_req_fifo.sv
// Small synchronous FIFO with a combinational read head and no write bypass.
module req_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only readable once written, so a flush is just the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/arb_requester.sv
// Requester agent: queues words, requests the arbiter, owns the bus for a whole packet.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input logic              clk,
  input logic              reset,
  arb_requester_if.master  bus_if
);
  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  req_state_t        state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic [DATA_W:0]   head;
  logic              full, empty, push, pop, head_last, bus_valid;
  logic [CW-1:0]     count;

  assign push      = bus_if.in_valid & ~full;
  assign head_last = head[DATA_W];
  // An empty FIFO mid-packet or a missing grant stalls the beat without giving up ownership.
  assign bus_valid = (state == XFER) & ~empty & bus_if.gnt;
  assign pop       = bus_valid & bus_if.bus_ready;

  req_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({bus_if.in_last, bus_if.in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus_if.in_ready      = ~full;
  assign bus_if.req           = (state != IDLE);
  assign bus_if.bus_valid     = bus_valid;
  assign bus_if.bus_data      = head[DATA_W-1:0];
  assign bus_if.bus_last      = head_last;
  assign bus_if.release_pulse = pop & head_last;
  assign bus_if.starve        = (wait_cnt >= WAIT_W'(MAX_WAIT));
  assign bus_if.err           = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= STATE_RST;
    else       state <= state_next;
  end

  // NOTE: next state defaults to the current state first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!empty) state_next = REQ;
      REQ:  if (bus_if.gnt) state_next = XFER;
      XFER: begin
        // Post-pop occupancy decides whether to re-request for a queued packet.
        if (pop && head_last) state_next = ((count > CW'(1)) || push) ? REQ : IDLE;
      end
      default: state_next = STATE_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      case (state)
        REQ: begin
          if (bus_if.gnt)               wait_cnt <= '0;
          else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
        end
        XFER:    wait_cnt <= wait_cnt;
        default: wait_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            err_q <= ERR_RST;
    else if (state == XFER && !bus_if.gnt) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_arb_requester.sv
// Randomised and directed bench for arb_requester with a packet-level scoreboard.
module tb_arb_requester;
  import arb_pkg::*;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 200;
  localparam int WAIT_SAT = 255;

  logic clk = 1'b0;
  logic reset;

  arb_requester_if #(.DATA_W(DATA_W)) bif ();

  arb_requester #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .WAIT_W   (8),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rel_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO contents as a queue plus packet-level ownership flags.
  beat_t sb[$];
  bit    owning, requesting, err_m;
  int    waited;

  always @(negedge clk) begin
    bit    in_ready_e, bv_e, push_e, pop_d, last_done;
    int    pre_size;
    beat_t b;
    if (reset) begin
      sb.delete();
      owning = 0; requesting = 0; err_m = 0; waited = 0;
    end
    in_ready_e = (sb.size() < DEPTH);
    bv_e       = owning && (sb.size() > 0) && (bif.gnt === 1'b1);
    check("in_ready",  bif.in_ready,  in_ready_e);
    check("req",       bif.req,       owning | requesting);
    check("bus_valid", bif.bus_valid, bv_e);
    check("starve",    bif.starve,    waited >= MAX_WAIT);
    check("err",       bif.err,       err_m);
    check("wait_cnt",  dut.wait_cnt,  waited);
    if (sb.size() > 0) begin
      check("bus_data_head", bif.bus_data, sb[0].data);
      check("bus_last_head", bif.bus_last, sb[0].last);
    end
    if (bif.release_pulse === 1'b1) rel_seen++;
    pop_d = (bif.bus_valid === 1'b1) && (bif.bus_ready === 1'b1);
    if (pop_d) begin
      if (sb.size() == 0) check("beat_unexpected", pop_d, 1'b0);
      else                check("release", bif.release_pulse, sb[0].last);
    end else begin
      check("release_idle", bif.release_pulse, 1'b0);
    end
    if (!reset) begin
      pre_size  = sb.size();
      push_e    = (bif.in_valid === 1'b1) && in_ready_e;
      last_done = 0;
      if (pop_d && sb.size() > 0) begin
        b = sb.pop_front();
        last_done = b.last;
      end
      if (push_e) sb.push_back(beat_t'{last: bif.in_last, data: bif.in_data});
      if (owning && bif.gnt !== 1'b1) err_m = 1;
      if (requesting)   waited = (bif.gnt === 1'b1) ? 0 : ((waited < WAIT_SAT) ? waited + 1 : WAIT_SAT);
      else if (!owning) waited = 0;
      if (requesting) begin
        if (bif.gnt === 1'b1) begin owning = 1; requesting = 0; end
      end else if (owning) begin
        if (last_done) begin owning = 0; requesting = (sb.size() > 0); end
      end else begin
        requesting = (pre_size > 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    bit done = 0;
    bif.in_valid = 1'b1; bif.in_data = d; bif.in_last = l;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bif.in_ready === 1'b1) done = 1;
      tick();
    end
    bif.in_valid = 1'b0;
    check("push_timeout", done, 1'b1);
  endtask

  task automatic wait_beat();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bif.bus_valid === 1'b1 && bif.bus_ready === 1'b1) ok = 1;
    end
    tick();
    check("beat_timeout", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.in_valid = 0; bif.in_data = '0; bif.in_last = 0;
    bif.gnt = 0; bif.bus_ready = 0; reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // Single-word packet with the grant already present.
    bif.gnt = 1; bif.bus_ready = 1;
    push_word(32'hA5A5_0001, 1'b1);
    repeat (4) tick();
    check("t1_releases", rel_seen, 1);

    // Three-word packet with a delayed grant.
    bif.gnt = 0;
    push_word(32'h10, 1'b0); push_word(32'h11, 1'b0); push_word(32'h12, 1'b1);
    repeat (3) tick();
    bif.gnt = 1;
    repeat (6) tick();
    check("t2_releases", rel_seen, 2);

    // Fill while the sink stalls, then drain.
    bif.bus_ready = 0;
    for (int i = 0; i < 4; i++) push_word(32'h20 + i, i == 3);
    bif.in_valid = 1; bif.in_data = 32'hDEAD_BEEF; bif.in_last = 1;
    repeat (3) tick();
    check("t3_full", bif.in_ready, 1'b0);
    bif.in_valid = 0; bif.bus_ready = 1;
    repeat (6) tick();
    check("t3_releases", rel_seen, 3);

    // Grant drops for one cycle during beat 2.
    push_word(32'h30, 1'b0); push_word(32'h31, 1'b0); push_word(32'h32, 1'b1);
    wait_beat();
    bif.gnt = 0;
    tick();
    bif.gnt = 1;
    repeat (5) tick();
    check("t4_err", bif.err, 1'b1);
    check("t4_releases", rel_seen, 4);

    // Starvation and saturation.
    bif.gnt = 0;
    push_word(32'h40, 1'b1);
    repeat (260) tick();
    check("t5_starve", bif.starve, 1'b1);
    bif.gnt = 1;
    repeat (4) tick();
    check("t5_releases", rel_seen, 5);

    // Reset in the middle of a packet.
    push_word(32'h50, 1'b0); push_word(32'h51, 1'b0); push_word(32'h52, 1'b1);
    wait_beat();
    bif.bus_ready = 0; reset = 1'b1;
    #1;
    check("t6_req",       bif.req,           1'b0);
    check("t6_bus_valid", bif.bus_valid,     1'b0);
    check("t6_release",   bif.release_pulse, 1'b0);
    check("t6_in_ready",  bif.in_ready,      1'b1);
    check("t6_err",       bif.err,           1'b0);
    check("t6_starve",    bif.starve,        1'b0);
    repeat (2) tick();
    reset = 1'b0; bif.bus_ready = 1;
    push_word(32'hA5A5_0002, 1'b1);
    repeat (5) tick();
    check("t6_releases", rel_seen, 6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bif.in_valid  = $urandom_range(1, 0) == 1;
      bif.in_data   = $urandom;
      bif.in_last   = $urandom_range(2, 0) == 0;
      bif.gnt       = $urandom_range(15, 0) != 0;
      bif.bus_ready = $urandom_range(3, 0) != 0;
      tick();
    end
    bif.in_valid = 0; bif.in_last = 1; bif.gnt = 1; bif.bus_ready = 1;
    repeat (20) tick();
    check("drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
